// File: rtl/dmg_lcd_pkg.sv
// rtl/dmg_lcd_pkg.sv - shared constants and types for the DMG LCD frame capture
//
// Purpose: frame geometry and capture state encoding used by lcd_frame_capture.
// Ports: none (package).
package dmg_lcd_pkg;

  localparam int LCD_H_PIXELS       = 160;
  localparam int LCD_V_LINES        = 144;
  localparam int LCD_BYTES_PER_LINE = LCD_H_PIXELS / 4;
  localparam int LCD_FRAME_BYTES    = LCD_BYTES_PER_LINE * LCD_V_LINES;

  typedef enum logic {
    WAIT_VS,
    ACTIVE
  } cap_state_t;

endpackage

// File: rtl/lcd_edge_det.sv
// rtl/lcd_edge_det.sv - registered rising-edge detector for LCD sync inputs
//
// Purpose: registers one sync input and flags the cycle after it rises.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   sig  - raw sync input
//   rise - one-cycle pulse, one clock after sig goes 0->1
module lcd_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic curr;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curr <= 1'b0;
      prev <= 1'b0;
    end else begin
      curr <= sig;
      prev <= curr;
    end
  end

  assign rise = curr & ~prev;

endmodule

// File: rtl/lcd_frame_capture.sv
// rtl/lcd_frame_capture.sv - DMG LCD pixel stream to double-banked framebuffer
//
// Purpose: counts pixels/lines of the PPU stream, packs four 2-bit pixels per
// byte and writes them to the back bank; a bank is promoted to the front only
// after a complete, error-free frame.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   lcd_vsync/hsync   - frame / line sync (rising edges used)
//   lcd_pixel/color   - pixel strobe and 2-bit shade
//   err_clr           - clears sticky error flags
//   fb_addr/data/we   - framebuffer write port {bank, offset}, packed byte
//   front_bank        - bank holding the last complete frame
//   frame_done/drop   - commit / discard pulses at each frame boundary
//   frame_count       - committed frame counter (wraps)
//   err_line          - sticky: a line ended with the wrong pixel count
//   err_overrun       - sticky: a pixel arrived outside the frame
module lcd_frame_capture
  import dmg_lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_vsync,
  input  logic        lcd_hsync,
  input  logic        lcd_pixel,
  input  logic [1:0]  lcd_color,
  input  logic        err_clr,
  output logic [13:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  output logic        front_bank,
  output logic        frame_done,
  output logic        frame_drop,
  output logic [7:0]  frame_count,
  output logic        err_line,
  output logic        err_overrun
);

  localparam logic [7:0]  H_PIX    = 8'(LCD_H_PIXELS);
  localparam logic [7:0]  V_LIN    = 8'(LCD_V_LINES);
  localparam logic [12:0] ROW_STEP = 13'(LCD_BYTES_PER_LINE);

  logic vs_rise, hs_rise;

  lcd_edge_det u_vs_det (.clk(clk), .rst(rst), .sig(lcd_vsync), .rise(vs_rise));
  lcd_edge_det u_hs_det (.clk(clk), .rst(rst), .sig(lcd_hsync), .rise(hs_rise));

  cap_state_t  state, state_d;
  logic [7:0]  x, x_d, y, y_d;
  logic [12:0] row_base, row_base_d;
  logic [7:0]  pack, pack_d;
  logic        frame_bad, frame_bad_d;
  logic        write_bank, write_bank_d;
  logic        front_bank_d, frame_done_d, frame_drop_d;
  logic [7:0]  frame_count_d;
  logic        fb_we_d;
  logic [7:0]  fb_data_d;
  logic [13:0] fb_addr_d;
  logic        set_line, set_overrun;
  logic        in_bounds, pix_ok, line_end;
  logic [7:0]  x_eff, pack_eff;
  logic [1:0]  pad;

  always_comb begin
    state_d       = state;
    x_d           = x;
    y_d           = y;
    row_base_d    = row_base;
    pack_d        = pack;
    frame_bad_d   = frame_bad;
    write_bank_d  = write_bank;
    front_bank_d  = front_bank;
    frame_count_d = frame_count;
    frame_done_d  = 1'b0;
    frame_drop_d  = 1'b0;
    fb_we_d       = 1'b0;
    fb_data_d     = fb_data;
    fb_addr_d     = fb_addr;
    set_line      = 1'b0;
    set_overrun   = 1'b0;

    // A pixel coinciding with the line-end edge belongs to the ending line,
    // so the "effective" x/pack already include it.
    in_bounds = (x < H_PIX) && (y < V_LIN);
    pix_ok    = lcd_pixel && in_bounds;
    x_eff     = pix_ok ? x + 8'd1 : x;
    pack_eff  = pix_ok ? {pack[5:0], lcd_color} : pack;
    line_end  = hs_rise && (y < V_LIN);
    // Slots still empty in the byte; a full byte needs no shift.
    pad       = 2'd0 - x_eff[1:0];

    case (state)
      WAIT_VS: begin
        if (vs_rise) begin
          state_d     = ACTIVE;
          x_d         = 8'd0;
          y_d         = 8'd0;
          row_base_d  = 13'd0;
          pack_d      = 8'd0;
          frame_bad_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          if (y == V_LIN && !frame_bad) begin
            frame_done_d  = 1'b1;
            front_bank_d  = write_bank;
            write_bank_d  = ~write_bank;
            frame_count_d = frame_count + 8'd1;
          end else begin
            frame_drop_d = 1'b1;
          end
          x_d         = 8'd0;
          y_d         = 8'd0;
          row_base_d  = 13'd0;
          pack_d      = 8'd0;
          frame_bad_d = 1'b0;
        end else begin
          if (lcd_pixel && !in_bounds) begin
            set_overrun = 1'b1;
            frame_bad_d = 1'b1;
          end
          // Byte index is x[7:2] for both a completed byte and a partial
          // flush, since a flush never follows a byte-completing pixel.
          if ((pix_ok && x[1:0] == 2'd3) || (line_end && x_eff[1:0] != 2'd0)) begin
            fb_we_d   = 1'b1;
            fb_data_d = pack_eff << {pad, 1'b0};
            fb_addr_d = {write_bank, row_base + {7'd0, x[7:2]}};
          end
          if (line_end) begin
            if (x_eff != H_PIX) begin
              set_line    = 1'b1;
              frame_bad_d = 1'b1;
            end
            x_d        = 8'd0;
            pack_d     = 8'd0;
            y_d        = y + 8'd1;
            row_base_d = row_base + ROW_STEP;
          end else begin
            x_d    = x_eff;
            pack_d = pack_eff;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_VS;
      x           <= 8'd0;
      y           <= 8'd0;
      row_base    <= 13'd0;
      pack        <= 8'd0;
      frame_bad   <= 1'b0;
      write_bank  <= 1'b1;
      front_bank  <= 1'b0;
      frame_count <= 8'd0;
      frame_done  <= 1'b0;
      frame_drop  <= 1'b0;
      fb_we       <= 1'b0;
      fb_data     <= 8'd0;
      fb_addr     <= 14'd0;
      err_line    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_d;
      x           <= x_d;
      y           <= y_d;
      row_base    <= row_base_d;
      pack        <= pack_d;
      frame_bad   <= frame_bad_d;
      write_bank  <= write_bank_d;
      front_bank  <= front_bank_d;
      frame_count <= frame_count_d;
      frame_done  <= frame_done_d;
      frame_drop  <= frame_drop_d;
      fb_we       <= fb_we_d;
      fb_data     <= fb_data_d;
      fb_addr     <= fb_addr_d;
      // A new error in the same cycle as a clear keeps the flag set.
      err_line    <= set_line    ? 1'b1 : (err_clr ? 1'b0 : err_line);
      err_overrun <= set_overrun ? 1'b1 : (err_clr ? 1'b0 : err_overrun);
    end
  end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// tb/tb_lcd_frame_capture.sv - scoreboard testbench for lcd_frame_capture
module tb_lcd_frame_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_vsync, lcd_hsync, lcd_pixel, err_clr;
  logic [1:0]  lcd_color;
  logic [13:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we, front_bank, frame_done, frame_drop;
  logic [7:0]  frame_count;
  logic        err_line, err_overrun;

  always #5 clk = ~clk;

  lcd_frame_capture dut (
    .clk(clk), .rst(rst),
    .lcd_vsync(lcd_vsync), .lcd_hsync(lcd_hsync),
    .lcd_pixel(lcd_pixel), .lcd_color(lcd_color), .err_clr(err_clr),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .front_bank(front_bank), .frame_done(frame_done), .frame_drop(frame_drop),
    .frame_count(frame_count), .err_line(err_line), .err_overrun(err_overrun)
  );

  typedef struct packed { logic [13:0] addr; logic [7:0] data; } wr_t;
  typedef struct packed { logic done; logic front; logic [7:0] count; } ev_t;

  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_wr    = 0;

  // Reference model of the frame/bank bookkeeping
  bit  m_active, m_wbank, m_front, m_bad, m_err_line, m_err_ovr;
  int  m_y, m_count;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_wbank = 1; m_front = 0; m_bad = 0;
    m_err_line = 0; m_err_ovr = 0; m_y = 0; m_count = 0;
  endtask

  task automatic model_vsync();
    if (m_active) begin
      if (m_y == 144 && !m_bad) begin
        m_front = m_wbank;
        m_wbank = !m_wbank;
        m_count = (m_count + 1) % 256;
        exp_ev.push_back('{done: 1'b1, front: m_front, count: 8'(m_count)});
      end else begin
        exp_ev.push_back('{done: 1'b0, front: m_front, count: 8'(m_count)});
      end
    end
    m_active = 1; m_y = 0; m_bad = 0;
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT produces output
  always @(negedge clk) begin : monitor
    wr_t w;
    ev_t e;
    if (rst) begin
      if (fb_we) begin
        n_wr++;
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", fb_addr, fb_data);
        end else begin
          w = exp_wr.pop_front();
          check("fb_addr", fb_addr, w.addr);
          check("fb_data", fb_data, w.data);
        end
      end
      if (frame_done || frame_drop) begin
        if (exp_ev.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_frame_event: done=%0b drop=%0b, expected none", frame_done, frame_drop);
        end else begin
          e = exp_ev.pop_front();
          check("frame_done", frame_done, e.done);
          check("frame_drop", frame_drop, !e.done);
          check("front_bank", front_bank, e.front);
          check("frame_count", frame_count, e.count);
        end
      end
    end
  end

  task automatic cyc(input bit pix, input logic [1:0] col, input bit hs, input bit vs);
    lcd_pixel = pix; lcd_color = col; lcd_hsync = hs; lcd_vsync = vs;
    @(posedge clk); #1;
  endtask

  task automatic do_vsync();
    model_vsync();
    cyc(0, 2'd0, 0, 1);
    cyc(0, 2'd0, 0, 0);
    @(negedge clk); #1;
    check("events_pending", exp_ev.size(), 0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(0, 2'd0, 0, 0);
    err_clr = 1'b0;
    m_err_line = 0; m_err_ovr = 0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_err_line"}, err_line, m_err_line);
    check({tag, "_err_overrun"}, err_overrun, m_err_ovr);
  endtask

  // mode: 0 random shades, 1 shade = x mod 4, 2 all shade 3
  // end_mode: 0 hsync after line, 1 hsync edge on last pixel,
  //           2 hsync+vsync together, 3 stop mid-line (no sync)
  task automatic drive_line(input int n, input int mode, input int end_mode, input bit gaps);
    logic [1:0] col[$];
    logic [7:0] byt;
    int k, nb;
    for (int i = 0; i < n; i++)
      col.push_back(mode == 0 ? 2'($urandom_range(0, 3)) : (mode == 1 ? 2'(i % 4) : 2'd3));
    if (m_active) begin
      if (m_y < 144) begin
        k = (n < 160) ? n : 160;
        if (n > 160) begin m_err_ovr = 1; m_bad = 1; end
        nb = (end_mode >= 2) ? k / 4 : (k + 3) / 4;
        for (int b = 0; b < nb; b++) begin
          byt = 8'd0;
          for (int j = 0; j < 4; j++)
            if (4 * b + j < k) byt = byt | (8'(col[4 * b + j]) << (6 - 2 * j));
          exp_wr.push_back('{addr: {m_wbank, 13'(m_y * 40 + b)}, data: byt});
        end
        if (end_mode < 2) begin
          if (k != 160) begin m_err_line = 1; m_bad = 1; end
          m_y++;
        end
      end else if (n > 0) begin
        m_err_ovr = 1; m_bad = 1;
      end
    end
    if (end_mode == 2) model_vsync();
    for (int i = 0; i < n; i++) begin
      if (gaps && i != n - 1 && $urandom_range(0, 15) == 0) cyc(0, 2'd0, 0, 0);
      cyc(1, col[i], (end_mode == 1 && i == n - 2), 0);
    end
    case (end_mode)
      0: begin cyc(0, 2'd0, 1, 0); cyc(0, 2'd0, 0, 0); end
      1: cyc(0, 2'd0, 0, 0);
      2: begin cyc(0, 2'd0, 1, 1); cyc(0, 2'd0, 0, 0); end
      default: ;
    endcase
  endtask

  task automatic full_frame(input int mode, input int early_line);
    for (int l = 0; l < 144; l++) drive_line(160, mode, (l == early_line) ? 1 : 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_fb_data"}, fb_data, 0);
    check({tag, "_fb_we"}, fb_we, 0);
    check({tag, "_front_bank"}, front_bank, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_drop"}, frame_drop, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_err_line"}, err_line, 0);
    check({tag, "_err_overrun"}, err_overrun, 0);
  endtask

  initial begin
    int w0;
    rst = 1'b0; err_clr = 1'b0;
    lcd_vsync = 0; lcd_hsync = 0; lcd_pixel = 0; lcd_color = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    cyc(0, 2'd0, 0, 0);

    // Pixels and hsync before the first vsync are ignored
    drive_line(160, 0, 0, 1);

    // Clean frame of x mod 4 shades into bank 1
    do_vsync();
    w0 = n_wr;
    full_frame(1, -1);
    do_vsync();
    check("frame1_writes", n_wr - w0, 5760);
    check("frame1_front", front_bank, m_front);
    check("frame1_count", frame_count, m_count);

    // Second clean frame into bank 0, one line ends with hsync on its last pixel
    w0 = n_wr;
    full_frame(0, 20);
    do_vsync();
    check("frame2_writes", n_wr - w0, 5760);
    check("frame2_front", front_bank, m_front);
    check("frame2_count", frame_count, m_count);

    // Short line 10 -> line error, frame dropped
    for (int l = 0; l < 10; l++) drive_line(160, 0, 0, 1);
    drive_line(158, 2, 0, 1);
    check_flags("short_line");
    drive_line(160, 0, 0, 1);
    do_vsync();
    check("drop_front", front_bank, m_front);
    clear_err();
    check_flags("clr1");

    // Over-long line -> overrun, then cleared
    drive_line(160, 0, 0, 1);
    drive_line(163, 0, 0, 1);
    check_flags("long_line");
    clear_err();
    check_flags("clr2");
    do_vsync();

    // Clean frame rewriting the same back bank, plus an ignored extra hsync
    full_frame(0, -1);
    drive_line(0, 0, 0, 0);
    do_vsync();
    check("frame3_front", front_bank, m_front);
    check("frame3_count", frame_count, m_count);

    // hsync and vsync together: vsync wins, next frame restarts at row 0
    drive_line(160, 0, 0, 1);
    drive_line(160, 0, 0, 1);
    drive_line(160, 0, 2, 0);

    // Asynchronous reset in the middle of line 50
    for (int l = 0; l < 50; l++) drive_line(160, 0, 0, 1);
    drive_line(70, 0, 3, 0);
    #2;
    rst = 1'b0;
    lcd_pixel = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_wr.delete();
    exp_ev.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_line(160, 0, 0, 1);
    do_vsync();
    drive_line(160, 0, 0, 1);
    drive_line(160, 0, 0, 1);
    do_vsync();
    check("post_reset_front", front_bank, m_front);
    check("post_reset_count", frame_count, m_count);

    repeat (4) cyc(0, 2'd0, 0, 0);
    check("writes_pending", exp_wr.size(), 0);
    check("events_left", exp_ev.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_frame_capture.md
Name: lcd_frame_capture

Overview:
Receiver for the DMG LCD pixel stream (lcd_vsync, lcd_hsync, lcd_pixel, lcd_color) produced by the PPU. Counts pixels and lines, packs four 2-bit pixels per byte, and writes the bytes into a double-banked framebuffer RAM. Each bank holds 5760 bytes for a 160x144 frame. A bank is swapped to the front only when a frame arrives complete and clean, so the downstream scanout (HDMI/LCD panel driver) never shows a torn frame.

Parameters:
H_PIXELS, 160, pixels per line
V_LINES, 144, lines per frame
BYTES_PER_LINE, H_PIXELS/4 (40), packed bytes per line

Ports:
clk  in  1  system clock, same domain as the PPU
rst  in  1  asynchronous, active-low reset
lcd_vsync  in  1  frame sync; rising edge starts a new frame
lcd_hsync  in  1  line sync; rising edge ends the current line
lcd_pixel  in  1  pixel strobe; lcd_color is valid on cycles where it is high
lcd_color  in  2  pixel shade 0..3
err_clr  in  1  one-cycle pulse; clears sticky error flags
fb_addr  out  14  {write_bank, byte offset 0..5759}
fb_data  out  8  packed pixels; first pixel in [7:6], fourth in [1:0]
fb_we  out  1  framebuffer write strobe
front_bank  out  1  bank holding the last complete frame
frame_done  out  1  one-cycle pulse when a clean frame is committed
frame_drop  out  1  one-cycle pulse when an incomplete or erroneous frame is discarded
frame_count  out  8  count of committed frames; wraps 255->0
err_line  out  1  sticky: a line ended with x != H_PIXELS
err_overrun  out  1  sticky: a pixel arrived with x >= H_PIXELS or y >= V_LINES

Behaviour:
- Reset (async, rst=0) clears all outputs and state: fb_addr=0, fb_data=0, fb_we=0, front_bank=0, write_bank=1, frame_done=0, frame_drop=0, frame_count=0, both error flags 0, state=WAIT_VS, x=0, y=0, row_base=0, frame_bad=0.
- Sync edges: lcd_vsync and lcd_hsync are registered once. A rising edge is curr & ~prev. This adds one cycle of edge latency; lcd_pixel and lcd_color are used unregistered.
- State WAIT_VS: pixel strobes and hsync are ignored. On a vsync rise, go to ACTIVE with x=0, y=0, row_base=0, frame_bad=0. No frame_done or frame_drop is issued.
- State ACTIVE, pixel strobe with x<H_PIXELS and y<V_LINES:
  - pack <= {pack[5:0], lcd_color}; x++.
  - When x[1:0]==3, on the next cycle: fb_we=1, fb_data=packed byte, fb_addr={write_bank, row_base + x[7:2]}.
  - Write latency is 1 clk after the 4th strobe. fb_we is high for exactly one cycle per byte.
- Pixel strobe with x>=H_PIXELS or y>=V_LINES: the pixel is dropped, err_overrun=1, frame_bad=1.
- hsync rise in ACTIVE:
  - If x!=H_PIXELS: err_line=1, frame_bad=1.
  - If x[1:0]!=0: flush the partial byte, left-justified and zero-padded, with one fb_we.
  - Then x=0. If y<V_LINES: y++ and row_base+=40. row_base is accumulated, never multiplied.
  - Additional hsync rises with y==V_LINES are ignored.
- vsync rise in ACTIVE: ends the previous frame and starts a new one.
  - If y==V_LINES and frame_bad==0: frame_done pulse, front_bank<=write_bank, write_bank toggles, frame_count++.
  - Otherwise: frame_drop pulse, banks unchanged (the same back bank is rewritten).
  - In both cases: x=0, y=0, row_base=0, pack=0, frame_bad=0.
- Same-cycle events:
  - Pixel with hsync edge: the pixel belongs to the current line and is packed first. The flush and line advance include it.
  - hsync edge with vsync edge: vsync wins; the hsync edge is discarded and does not count toward y.
  - err_clr with an error event: the set wins.
- Mid-frame reset: state and banks return to reset values immediately, and any partial write is abandoned. The first frame after reset is never committed because WAIT_VS skips it.
- Write throughput: at most one fb_we per 4 pixel strobes plus one flush per line. No backpressure exists; the RAM must accept a write on any cycle.

Decomposition:
- Package dmg_lcd_pkg:
  - LCD_H_PIXELS=160, LCD_V_LINES=144, LCD_BYTES_PER_LINE=40, LCD_FRAME_BYTES=5760.
  - cap_state_t enum {WAIT_VS, ACTIVE}.
- One sub-module, lcd_edge_det: async active-low reset; registers one input and emits a rising-edge pulse. It is instantiated twice, for hsync and vsync.

Test Plan:
1. Reset, vsync, 144 lines of 160 pixels with color=(x mod 4), vsync -> 5760 fb_we, every fb_data=8'h1B, addresses 0x2000..0x367F, frame_done=1, front_bank=1, frame_count=1.
2. Continue with a second clean frame -> writes go to 0x0000..0x167F, front_bank=0, frame_count=2.
3. Line 10 with only 158 pixels, all color 3 -> last byte of that line is 8'hF0, err_line=1, the next vsync gives frame_drop=1, front_bank unchanged, the following clean frame rewrites the same bank.
4. 163 pixels on one line -> 40 writes for that line, err_overrun=1; an err_clr pulse then returns the flag to 0.
5. Same-cycle hsync+pixel on the 160th pixel -> the byte is written and the line advances once; same-cycle hsync+vsync -> y resets to 0 and no extra line is counted.
6. rst asserted mid-line 50 -> all outputs 0 asynchronously; the first vsync after reset starts capture with no frame_done or frame_drop pulse.
